// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one UART transmitter between NUM_REQ
//            byte producers, with inter-frame gap and hung-transmitter timeout.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 200000,
    parameter int GAP_CYC     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 timeout
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int c_GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYC - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              r_state;
    logic [2:0]          r_rr_ptr;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic                r_tx_done_q;

    logic                w_found;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_IDX_W-1:0]  w_win_idx;
    logic [2:0]          w_winner;
    logic [2:0]          w_rr_next;
    logic [7:0]          w_sel_data;
    logic                w_done_rise;

    // A level left high from a previous frame must not end the new one.
    assign w_done_rise = tx_done & ~r_tx_done_q;

    always_comb begin
        w_found   = 1'b0;
        w_idx     = '0;
        w_win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_idx;
            end
        end
    end

    assign w_winner  = 3'(w_win_idx);
    assign w_rr_next = (w_winner == 3'(NUM_REQ - 1)) ? 3'd0 : w_winner + 3'd1;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_sel_data = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_tx_done_q <= 1'b0;
            req_ack     <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout     <= 1'b0;
        end else begin
            r_tx_done_q <= tx_done;
            req_ack     <= '0;
            tx_start    <= 1'b0;
            timeout     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        tx_data  <= w_sel_data;
                        grant_id <= w_winner;
                        r_rr_ptr <= w_rr_next;
                        req_ack  <= NUM_REQ'(1) << w_win_idx;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_rise) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        timeout   <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Scoreboard bench for uart_tx_arbiter with a behavioural UART model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 40;
    localparam int GAP_CYC     = 4;
    localparam int FRAME       = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [2:0]  grant_id;
    logic        timeout;

    bit   auto_done = 1'b1;
    logic auto_q = 1'b0;
    logic man_done = 1'b0;
    assign tx_done = auto_done ? auto_q : man_done;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int exp_to = 0;
    int ucnt = 0;
    bit lat_chk = 1'b0;
    int load_cyc [4];

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] rq [4][$];

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .GAP_CYC    (GAP_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ack  (req_ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .grant_id (grant_id),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_frame(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = 3'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic request(input int id, input logic [7:0] d);
        rq[id].push_back(d);
    endtask

    // Requesters: hold each byte until acked, then present the next queued one.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (req_ack[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && rq[i].size() > 0) begin
                    req_data[8*i +: 8] = rq[i].pop_front();
                    req_valid[i] = 1'b1;
                    load_cyc[i] = cyc;
                end
            end
        end
    end

    // UART model: one-cycle done pulse FRAME cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            auto_q = 1'b0;
            if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) auto_q = 1'b1;
            end
            if (tx_start) ucnt = FRAME;
        end
    end

    // Monitor: every start pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (tx_start) begin
                    chk("start_has_expect", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("tx_data", 32'(tx_data), 32'(e.data));
                        chk("grant_id", 32'(grant_id), 32'(e.id));
                        chk("req_ack", 32'(req_ack), 32'(1) << e.id);
                        chk("busy_at_start", 32'(busy), 1);
                        if (lat_chk) chk("grant_latency", 32'(cyc - load_cyc[e.id]), 1);
                    end
                end else if (req_ack != 0) begin
                    chk("ack_without_start", 32'(req_ack), 0);
                end
                if (timeout) begin
                    chk("timeout_expected", 32'(exp_to > 0), 1);
                    if (exp_to > 0) exp_to--;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) rq[i].delete();
        exp_q.delete();
        exp_to = 0;
        auto_done = 1'b1;
        man_done = 1'b0;
        lat_chk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy || exp_q.size() != 0 || req_valid != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(n < lim), 1);
    endtask

    task automatic wait_start(input int lim);
        int n = 1;
        @(negedge clk);
        while (!tx_start && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(tx_start), 1);
    endtask

    task automatic wait_timeout(input int lim);
        int n = 1;
        @(negedge clk);
        while (!timeout && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_seen", 32'(timeout), 1);
    endtask

    initial begin
        int s;
        int t0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ack", 32'(req_ack), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_timeout", 32'(timeout), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single request, one-cycle grant latency.
        lat_chk = 1'b1;
        expect_frame(0, 8'hA5);
        request(0, 8'hA5);
        wait_idle(200);
        lat_chk = 1'b0;

        // Four simultaneous requests from rr_ptr=0.
        do_reset();
        expect_frame(0, 8'h11);
        expect_frame(1, 8'h22);
        expect_frame(2, 8'h33);
        expect_frame(3, 8'h44);
        for (int i = 0; i < 4; i++) request(i, 8'(8'h11 * (i + 1)));
        wait_idle(500);

        // Fairness: req0 continuously valid, req2 once.
        do_reset();
        expect_frame(0, 8'h50);
        expect_frame(2, 8'h70);
        expect_frame(0, 8'h51);
        expect_frame(0, 8'h52);
        expect_frame(0, 8'h53);
        for (int i = 0; i < 4; i++) request(0, 8'(8'h50 + i));
        request(2, 8'h70);
        wait_idle(600);

        // Hung transmitter: timeout, gap, then next grant.
        do_reset();
        auto_done = 1'b0;
        expect_frame(1, 8'h3C);
        request(1, 8'h3C);
        exp_to = 1;
        wait_start(20);
        s = cyc;
        wait_timeout(100);
        chk("timeout_latency", 32'(cyc - s), 32'(TIMEOUT_CYC + 1));
        chk("busy_in_gap", 32'(busy), 1);
        t0 = cyc;
        @(negedge clk);
        chk("timeout_width", 32'(timeout), 0);
        expect_frame(3, 8'h9E);
        request(3, 8'h9E);
        wait_start(50);
        chk("regrant_after_gap", 32'(cyc - t0), 32'(GAP_CYC + 1));
        repeat (5) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        wait_idle(100);

        // Asynchronous reset mid-WAIT, then re-grant from rr_ptr=0.
        do_reset();
        auto_done = 1'b0;
        expect_frame(2, 8'h5A);
        request(2, 8'h5A);
        wait_start(20);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_tx_data", 32'(tx_data), 0);
        chk("async_rst_grant_id", 32'(grant_id), 0);
        chk("async_rst_ack_start", 32'({req_ack, tx_start, timeout}), 0);
        auto_done = 1'b1;
        expect_frame(1, 8'h61);
        expect_frame(3, 8'h63);
        request(1, 8'h61);
        request(3, 8'h63);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_idle(300);

        // Stale high tx_done must not end the frame early.
        do_reset();
        auto_done = 1'b0;
        man_done = 1'b1;
        repeat (3) @(negedge clk);
        expect_frame(0, 8'hC3);
        request(0, 8'hC3);
        wait_start(20);
        repeat (10) @(negedge clk);
        chk("stale_done_ignored", 32'(busy), 1);
        man_done = 1'b0;
        repeat (2) @(negedge clk);
        man_done = 1'b1;
        repeat (GAP_CYC) @(negedge clk);
        chk("busy_through_gap", 32'(busy), 1);
        @(negedge clk);
        chk("idle_after_gap", 32'(busy), 0);
        man_done = 1'b0;

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        chk("timeouts_drained", 32'(exp_to), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

`default_nettype wire
